// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request in
// flight to instruction memory, and buffers returned words with their PCs in a
// two-entry queue feeding decode over a valid/ready handshake.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_INC    = 4,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic        id_illegal
);

    localparam logic [31:0] Nop    = 32'h0000_0013;
    localparam logic [31:0] PcStep = 32'(PC_INC);
    localparam logic [1:0]  Depth  = 2'(BUF_DEPTH);

    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StWait  = 2'b01,
        StDrain = 2'b10
    } state_e;

    typedef enum logic [6:0] {
        OpRType  = 7'b0110011,
        OpIType  = 7'b0010011,
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpBranch = 7'b1100011,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpAuipc  = 7'b0010111,
        OpLui    = 7'b0110111
    } opcode_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d, discard_rst;
    logic        init_q;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];

    logic        req_valid;
    logic        accept;
    logic        pop;
    logic        push;
    logic        wr_idx;
    logic [31:0] target;
    logic [6:0]  head_op;

    assign accept = req_valid && imem_req_ready;
    assign pop    = id_valid && id_ready;
    assign wr_idx = head_q ^ count_q[0];
    assign target = {redirect_pc[31:2], 2'b00};

    // A response that is still in flight when reset hits must be swallowed later.
    assign discard_rst = (((state_q != StFetch) || discard_q) && !imem_rsp_valid) || accept;

    // Request gating: queue entries plus in-flight fetches never exceed the depth.
    always_comb begin
        req_valid = 1'b0;
        unique case (state_q)
            StFetch: req_valid = init_q && !discard_q && (count_q < Depth);
            // Re-issue alongside the response only if the pushed word still leaves room.
            StWait:  req_valid = imem_rsp_valid &&
                                 ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
            default: req_valid = 1'b0;
        endcase
    end

    // Next-state for FSM, fetch PC and instruction queue.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        count_d     = count_q;
        head_d      = head_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        push        = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (discard_q && imem_rsp_valid) discard_d = 1'b0;
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (imem_rsp_valid) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        if (accept) begin
            state_d  = StWait;
            req_pc_d = pc_q;
            pc_d     = pc_q + PcStep;
        end

        if (redirect_valid) begin
            // Anything still owed by memory after this cycle is stale.
            push    = 1'b0;
            count_d = 2'd0;
            head_d  = 1'b0;
            pc_d    = target;
            if (accept || ((state_q != StFetch) && !imem_rsp_valid)) begin
                state_d = StDrain;
            end else begin
                state_d = StFetch;
            end
        end else begin
            if (push) begin
                buf_instr_d[wr_idx] = imem_rsp_data;
                buf_pc_d[wr_idx]    = req_pc_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) head_d = ~head_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            discard_q   <= discard_rst;
            init_q      <= 1'b0;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            buf_instr_q <= '{default: 32'h0};
            buf_pc_q    <= '{default: 32'h0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
            init_q      <= 1'b1;
            count_q     <= count_d;
            head_q      <= head_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // Decode-facing outputs come straight from the queue head.
    always_comb begin
        imem_req_valid = req_valid;
        imem_req_addr  = pc_q;
        id_valid       = (count_q != 2'd0);
        id_instr       = id_valid ? buf_instr_q[head_q] : Nop;
        id_pc          = id_valid ? buf_pc_q[head_q] : 32'h0;
        head_op        = id_instr[6:0];
        id_opcode      = head_op;
        id_illegal     = id_valid && !(head_op inside {OpRType, OpIType, OpLoad, OpStore,
                                                       OpBranch, OpJal, OpJalr, OpAuipc,
                                                       OpLui});
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a memory responder plus a
// transaction-level model (expected fetch PC, in-order delivery queue).
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic        id_illegal;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .id_illegal     (id_illegal)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] exp_pc;
    bit          mem_busy;
    bit          mem_stale;
    int          mem_due;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] ovr_data[$];
    bit          model_live = 0;
    logic [6:0]  op_tab [10];

    // Stimulus knobs
    int p_rdy = 100, p_idr = 100, d_min = 1, d_max = 1, p_spur = 0;

    // Observation logs and per-cycle snapshot
    logic [31:0] acc_log[$];
    logic [31:0] deliv_pc_log[$];
    bit          deliv_ill_log[$];
    logic        s_req_valid, s_id_valid, s_ill;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        int idx;
        idx = int'(a[5:2] ^ a[9:6]) % 10;
        return {a[26:2], op_tab[idx]};
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        for (int i = 0; i < 9; i++) if (op == op_tab[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void clear_logs();
        acc_log.delete();
        deliv_pc_log.delete();
        deliv_ill_log.delete();
    endfunction

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic cycle(input bit do_rst, input bit do_redir, input logic [31:0] rpc);
        bit          responding, spur, acc, pp, push_m;
        int          occ;
        logic [31:0] h_instr;
        responding = mem_busy && (mem_due == 1);
        spur = !mem_busy && (p_spur > 0) && ($urandom_range(99) < p_spur);
        rst            = do_rst;
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        imem_rsp_valid = responding || spur;
        imem_rsp_data  = responding ? mem_data : $urandom;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        id_ready       = ($urandom_range(99) < p_idr);
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        pp  = id_valid && id_ready;
        s_req_valid = imem_req_valid; s_addr = imem_req_addr; s_id_valid = id_valid;
        s_instr = id_instr; s_pc = id_pc; s_ill = id_illegal;
        push_m = responding && !mem_stale && !do_redir && !do_rst;
        if (model_live) begin
            checks++;
            if (id_valid !== (q_pc.size() > 0)) begin
                errors++;
                $display("FAIL id_valid: got %b want %b", id_valid, q_pc.size() > 0);
            end
            if (q_pc.size() > 0) begin
                h_instr = q_instr[0];
                checks++;
                if (id_pc !== q_pc[0]) begin
                    errors++; $display("FAIL id_pc: got %h want %h", id_pc, q_pc[0]);
                end
                checks++;
                if (id_instr !== h_instr) begin
                    errors++; $display("FAIL id_instr: got %h want %h", id_instr, h_instr);
                end
                checks++;
                if (id_opcode !== h_instr[6:0]) begin
                    errors++; $display("FAIL id_opcode: got %h want %h", id_opcode, h_instr[6:0]);
                end
                checks++;
                if (id_illegal !== !legal_op(h_instr[6:0])) begin
                    errors++;
                    $display("FAIL id_illegal: got %b want %b", id_illegal, !legal_op(h_instr[6:0]));
                end
            end else begin
                checks++;
                if (id_instr !== 32'h0000_0013 || id_illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL empty_head: got instr %h ill %b want 00000013 0",
                             id_instr, id_illegal);
                end
            end
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_pc);
                end
            end
            if (acc) begin
                checks++;
                if (mem_busy && !responding) begin
                    errors++; $display("FAIL one_outstanding: got accept want none (busy)");
                end
            end
            if (!do_redir && !do_rst) begin
                occ = q_pc.size() - int'(pp) + int'(push_m) + int'(acc);
                checks++;
                if (occ > 2) begin
                    errors++; $display("FAIL occupancy: got %0d want <=2", occ);
                end
            end
        end
        if (acc) acc_log.push_back(imem_req_addr);
        if (pp) begin
            deliv_pc_log.push_back(id_pc);
            deliv_ill_log.push_back(id_illegal);
        end
        // Model advance
        if (pp && q_pc.size() > 0) begin
            void'(q_pc.pop_front());
            void'(q_instr.pop_front());
        end
        if (push_m) begin
            q_pc.push_back(mem_addr);
            q_instr.push_back(mem_data);
        end
        if (responding) mem_busy = 0;
        else if (mem_busy) mem_due--;
        if (do_redir || do_rst) begin
            q_pc.delete();
            q_instr.delete();
            if (mem_busy) mem_stale = 1;
        end
        if (acc) begin
            mem_busy  = 1;
            mem_due   = $urandom_range(d_max, d_min);
            mem_addr  = exp_pc;
            mem_data  = (ovr_data.size() > 0) ? ovr_data.pop_front() : instr_of(exp_pc);
            mem_stale = do_redir || do_rst;
            exp_pc    = exp_pc + 32'd4;
        end
        if (do_redir) exp_pc = rpc & 32'hFFFF_FFFC;
        if (do_rst) exp_pc = 32'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1; redirect_valid = 0; redirect_pc = 0; imem_rsp_valid = 0;
        imem_rsp_data = 0; imem_req_ready = 0; id_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_req: got %b %h want 0 00000000", imem_req_valid, imem_req_addr);
        end
        checks++;
        if (id_valid !== 1'b0 || id_instr !== 32'h13 || id_pc !== 32'h0 || id_illegal !== 1'b0)
        begin
            errors++;
            $display("FAIL reset_id: got v%b %h %h i%b want v0 00000013 00000000 i0",
                     id_valid, id_instr, id_pc, id_illegal);
        end
        @(posedge clk);
        #1;
        exp_pc = 32'h0; mem_busy = 0; mem_stale = 0; model_live = 1;
    endtask

    task automatic test_stream();
        int bubbles;
        bit seen;
        p_rdy = 100; p_idr = 100; d_min = 1; d_max = 1;
        clear_logs();
        bubbles = 0; seen = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (seen && !s_id_valid) bubbles++;
            if (s_id_valid) seen = 1;
        end
        checks++;
        if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 ||
            acc_log[2] !== 32'h8) begin
            errors++; $display("FAIL stream_addrs: got %p want 0,4,8,...", acc_log);
        end
        checks++;
        if (deliv_pc_log.size() < 3 || deliv_pc_log[0] !== 32'h0 || deliv_pc_log[1] !== 32'h4 ||
            deliv_pc_log[2] !== 32'h8) begin
            errors++; $display("FAIL stream_pcs: got %p want 0,4,8,...", deliv_pc_log);
        end
        checks++;
        if (bubbles != 0) begin
            errors++; $display("FAIL stream_bubbles: got %0d want 0", bubbles);
        end
    endtask

    task automatic test_backpressure();
        p_idr = 0;
        cycle(1'b1, 1'b0, 32'h0);
        clear_logs();
        run(14);
        checks++;
        if (s_id_valid !== 1'b1 || s_req_valid !== 1'b0 || s_addr !== 32'h8 || s_pc !== 32'h0)
        begin
            errors++;
            $display("FAIL bp_hold: got idv%b reqv%b addr %h idpc %h want 1 0 00000008 00000000",
                     s_id_valid, s_req_valid, s_addr, s_pc);
        end
        checks++;
        if (acc_log.size() != 2) begin
            errors++; $display("FAIL bp_count: got %0d want 2", acc_log.size());
        end
        clear_logs();
        p_idr = 100;
        run(10);
        checks++;
        if (deliv_pc_log.size() < 2 || deliv_pc_log[0] !== 32'h0 || deliv_pc_log[1] !== 32'h4)
        begin
            errors++; $display("FAIL bp_release: got %p want 0,4,...", deliv_pc_log);
        end
        checks++;
        if (acc_log.size() < 1 || acc_log[0] !== 32'h8) begin
            errors++; $display("FAIL bp_resume: got %p want 8,...", acc_log);
        end
    endtask

    task automatic test_redirect_drain();
        bit done;
        d_min = 3; d_max = 3; p_idr = 100; p_rdy = 100;
        cycle(1'b1, 1'b0, 32'h0);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (mem_busy && mem_addr == 32'h8 && mem_due > 1) begin
                cycle(1'b0, 1'b1, 32'h103);
                done = 1;
            end else begin
                cycle(1'b0, 1'b0, 32'h0);
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL drain_setup: got no in-flight 0x8 want one");
        end
        clear_logs();
        run(15);
        checks++;
        if (acc_log.size() < 1 || acc_log[0] !== 32'h100) begin
            errors++; $display("FAIL drain_addr: got %p want 100,...", acc_log);
        end
        checks++;
        if (deliv_pc_log.size() < 1 || deliv_pc_log[0] !== 32'h100) begin
            errors++; $display("FAIL drain_pc: got %p want 100,...", deliv_pc_log);
        end
    endtask

    task automatic test_redirect_same_cycle();
        bit          done;
        logic [31:0] h;
        d_min = 1; d_max = 1; p_idr = 100; p_rdy = 100;
        done = 0; h = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (mem_busy && mem_due == 1 && q_pc.size() > 0) begin
                h = q_pc[0];
                clear_logs();
                cycle(1'b0, 1'b1, 32'h200);
                done = 1;
            end else begin
                cycle(1'b0, 1'b0, 32'h0);
            end
        end
        checks++;
        if (!done || deliv_pc_log.size() != 1 || deliv_pc_log[0] !== h) begin
            errors++; $display("FAIL same_consumed: got %p want %h", deliv_pc_log, h);
        end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (s_id_valid !== 1'b0) begin
            errors++; $display("FAIL same_flush: got id_valid %b want 0", s_id_valid);
        end
        clear_logs();
        run(10);
        checks++;
        if (deliv_pc_log.size() < 1 || deliv_pc_log[0] !== 32'h200) begin
            errors++; $display("FAIL same_target: got %p want 200,...", deliv_pc_log);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        clear_logs();
        run(10);
        checks++;
        if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
            errors++; $display("FAIL wrap: got %p want fffffffc,0,...", acc_log);
        end
    endtask

    task automatic test_illegal_and_reset();
        bit done;
        d_min = 1; d_max = 1;
        cycle(1'b1, 1'b0, 32'h0);
        ovr_data.push_back(32'h0000_0033);
        ovr_data.push_back(32'h0000_0037);
        ovr_data.push_back(32'h0000_007F);
        clear_logs();
        run(10);
        checks++;
        if (deliv_ill_log.size() < 3 || deliv_ill_log[0] !== 1'b0 || deliv_ill_log[1] !== 1'b0 ||
            deliv_ill_log[2] !== 1'b1) begin
            errors++; $display("FAIL illegal_flags: got %p want 0,0,1", deliv_ill_log);
        end
        d_min = 3; d_max = 3;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (mem_busy && mem_due > 1) begin
                cycle(1'b1, 1'b0, 32'h0);
                done = 1;
            end else begin
                cycle(1'b0, 1'b0, 32'h0);
            end
        end
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (!done || s_req_valid !== 1'b0 || s_addr !== 32'h0 || s_id_valid !== 1'b0 ||
            s_instr !== 32'h13 || s_pc !== 32'h0 || s_ill !== 1'b0) begin
            errors++;
            $display("FAIL midrst: got rv%b %h iv%b %h %h il%b want 0 0 0 13 0 0",
                     s_req_valid, s_addr, s_id_valid, s_instr, s_pc, s_ill);
        end
        clear_logs();
        run(20);
        checks++;
        if (deliv_pc_log.size() < 1 || deliv_pc_log[0] !== 32'h0 || acc_log[0] !== 32'h0) begin
            errors++; $display("FAIL midrst_late: got %p want 0,...", deliv_pc_log);
        end
    endtask

    task automatic test_random();
        p_rdy = 70; p_idr = 60; d_min = 1; d_max = 3; p_spur = 5;
        clear_logs();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) < 4) cycle(1'b0, 1'b1, $urandom_range(32'h0000_0FFF));
            else cycle(1'b0, 1'b0, 32'h0);
        end
        p_spur = 0;
        checks++;
        if (deliv_pc_log.size() < 50) begin
            errors++; $display("FAIL random_progress: got %0d want >=50", deliv_pc_log.size());
        end
    endtask

    initial begin
        op_tab[0] = 7'h33; op_tab[1] = 7'h13; op_tab[2] = 7'h03; op_tab[3] = 7'h23;
        op_tab[4] = 7'h63; op_tab[5] = 7'h6F; op_tab[6] = 7'h67; op_tab[7] = 7'h17;
        op_tab[8] = 7'h37; op_tab[9] = 7'h7F;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_wrap();
        test_illegal_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core. Sits directly upstream of the decode stage, which uses the shared `parameters` package.
- Holds the PC and issues word fetches to instruction memory, allowing one request outstanding at a time.
- Buffers the returned instructions with their PCs in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Accepts redirects from execute (branch, JAL, JALR), flushes stale work, and pre-classifies the opcode against `opcode_t`.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_INC, 4, sequential increment; equals package `pcinc`.
- BUF_DEPTH, 2, instruction queue depth; fixed at 2, other values unsupported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  fetch address, word aligned.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  control-flow redirect from execute.
- redirect_pc  input  32  redirect target.
- id_valid  output  1  instruction available to decode.
- id_ready  input  1  decode accepts this cycle.
- id_instr  output  32  head instruction.
- id_pc  output  32  PC of head instruction.
- id_opcode  output  7  id_instr[6:0], typed `opcode_t`.
- id_illegal  output  1  opcode is not one of the 9 `opcode_t` encodings (R_type … LUI, incl. APUIPC).

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - id_valid=0, id_instr=32'h0000_0013 (NOP, ADDI x0), id_pc=0, id_illegal=0.
  - Queue empty, no request outstanding, FSM=FETCH.
- When rst is asserted mid-operation:
  - All state clears in the next cycle.
  - Any in-flight response arriving after reset is discarded, tracked by a discard flag set on reset when a request was outstanding.
- FSM states:
  - FETCH: imem_req_valid=1 when (count + outstanding) < BUF_DEPTH. On imem_req_ready, go to WAIT and latch the request PC.
  - WAIT: waiting for imem_rsp_valid. On response, push {req_pc, data} and go to FETCH. Same-cycle re-issue is allowed if space permits.
  - DRAIN: the outstanding response is stale. On imem_rsp_valid, drop it and go to FETCH.
- PC update:
  - The fetch PC advances by PC_INC on request acceptance.
  - 32-bit modulo wrap: 32'hFFFF_FFFC → 32'h0000_0000.
- Request rules:
  - imem_req_addr is stable while imem_req_valid=1 and imem_req_ready=0, except on redirect.
  - Response arrives ≥1 cycle after acceptance.
  - imem_rsp_valid with nothing outstanding is ignored.
- Queue:
  - A push is visible on id_valid the following cycle, so response-to-decode latency is 1 cycle.
  - Pop occurs when id_valid && id_ready.
  - Simultaneous push and pop with count==2 is impossible by the request-gating rule.
  - Simultaneous push and pop at count==1 leaves count=1.
- id outputs:
  - id_instr/id_pc/id_opcode/id_illegal reflect the queue head.
  - id_instr=NOP and id_illegal=0 when empty.
  - id_illegal is combinational from the head opcode.
- Redirect (redirect_valid=1 in cycle N):
  - Target is redirect_pc with bits [1:0] forced to 00.
  - Queue flushed; id_valid=0 in N+1.
  - A decode handshake occurring in N still counts as consumed.
  - Fetch PC := target.
  - If a request is outstanding or accepted in N, go to DRAIN; otherwise go to FETCH.
  - A response arriving in cycle N is discarded.
  - An unaccepted request in N is withdrawn; imem_req_addr=target in N+1.
- Redirect while in DRAIN: target updates and the state stays DRAIN; still exactly one stale response is dropped.
- Full queue (count==2): no requests issued; PC holds.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response, id_ready=1 → requests to 0x0,0x4,0x8; id_pc sequence 0x0,0x4,0x8 with matching instr, no bubbles after fill.
- id_ready=0 held → exactly 2 entries buffered, imem_req_valid drops, PC holds at 0x8; release id_ready → entries 0x0,0x4 delivered in order, fetch resumes at 0x8.
- Redirect to 0x103 while response for 0x8 outstanding → stale 0x8 data dropped, next request addr 0x100, first id_pc=0x100.
- Redirect in same cycle as imem_rsp_valid and id handshake → response discarded, queue empty next cycle, head consumed once.
- Fetch at 0xFFFF_FFFC → next request 0x0000_0000.
- Responses 0x0000_0033, 0x0000_0037, 0x0000_007F → id_illegal 0, 0, 1; mid-stream rst → all outputs at reset values next cycle, late response ignored.
